// File: rtl/falu_pkg.sv
// falu_pkg: shared definitions for the FALU issue controller.
//   - FALU opcodes (arithmetic 0-3, compares 4-6, OP_NONE parks the FALU)
//   - controller state encoding
//   - bit positions inside the 3-bit {exc,ovf,unf} flag vector
package falu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_MUL  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd3;
  localparam logic [3:0] OP_FEQ  = 4'd4;
  localparam logic [3:0] OP_FLT  = 4'd5;
  localparam logic [3:0] OP_FLE  = 4'd6;
  localparam logic [3:0] OP_NONE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int FLG_EXC = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UNF = 0;

  // Flag pattern reported for an illegal opcode or a NaN compare operand.
  localparam logic [2:0] FLAGS_INVALID = 3'b100;

  function automatic logic is_addsub(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic is_cmp(input logic [3:0] op);
    return (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE);
  endfunction

endpackage

// File: rtl/falu_cmp.sv
// falu_cmp: combinational IEEE-754 single-precision compare.
// Ports:
//   a_i, b_i : operands
//   eq_o     : a == b (+0 equals -0), 0 if either operand is NaN
//   lt_o     : a <  b, 0 if either operand is NaN
//   nan_o    : either operand is a NaN
module falu_cmp (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        eq_o,
  output logic        lt_o,
  output logic        nan_o
);

  logic a_nan;
  logic b_nan;
  logic both_zero;

  assign a_nan     = (&a_i[30:23]) && (|a_i[22:0]);
  assign b_nan     = (&b_i[30:23]) && (|b_i[22:0]);
  assign both_zero = ~(|a_i[30:0]) && ~(|b_i[30:0]);
  assign nan_o     = a_nan || b_nan;
  assign eq_o      = !nan_o && ((a_i == b_i) || both_zero);

  // Sign/magnitude ordering: with equal signs the magnitude decides,
  // reversed for negatives. Signed zeros are excluded up front.
  always_comb begin
    lt_o = 1'b0;
    if (!nan_o && !both_zero) begin
      case ({a_i[31], b_i[31]})
        2'b10:   lt_o = 1'b1;
        2'b01:   lt_o = 1'b0;
        2'b00:   lt_o = a_i[30:0] < b_i[30:0];
        default: lt_o = b_i[30:0] < a_i[30:0];
      endcase
    end
  end

endmodule

// File: rtl/falu_issue_ctrl.sv
// falu_issue_ctrl: issues one FP request at a time to the combinational FALU,
// holds its operands stable for a per-op settle latency, then captures the
// result and flags into a response register. Accrues sticky flags.
//
// Optional feature macro: FALU_CMP_EN -- when defined, ops 4/5/6 (FEQ/FLT/FLE)
// are resolved by the internal falu_cmp on the registered operands with
// latency 1; when undefined they are illegal ops.
//
// Ports:
//   CLK, RESET               clock, synchronous active-high reset
//   flush                    cancel any in-flight op, no response
//   req_valid/ready/op/a/b/rd request handshake and payload
//   falu_a/b/op              operands/opcode driven to the FALU (held)
//   falu_result/exc/ovf/unf  FALU outputs
//   rsp_valid/ready/data/rd/flags  response handshake and payload
//   flags_sticky, flags_clr  accrued {exc,ovf,unf}, clear request
//   busy                     high while an op is executing or awaiting pickup
module falu_issue_ctrl
  import falu_pkg::*;
#(
  parameter int ADD_LAT = 2,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 6,
  parameter int CNT_W   = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] falu_a,
  output logic [31:0] falu_b,
  output logic [3:0]  falu_op,
  input  logic [31:0] falu_result,
  input  logic        falu_exc,
  input  logic        falu_ovf,
  input  logic        falu_unf,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic [2:0]  rsp_flags,
  output logic [2:0]  flags_sticky,
  input  logic        flags_clr,
  output logic        busy
);

  if ((ADD_LAT < 1) || (MUL_LAT < 1) || (DIV_LAT < 1)) begin : g_bad_lat
    $error("falu_issue_ctrl: latency parameters must be >= 1");
  end
  if ((ADD_LAT >= (1 << CNT_W)) || (MUL_LAT >= (1 << CNT_W)) ||
      (DIV_LAT >= (1 << CNT_W))) begin : g_bad_cnt_w
    $error("falu_issue_ctrl: CNT_W too narrow for the latency parameters");
  end

  function automatic logic op_legal(input logic [3:0] op);
`ifdef FALU_CMP_EN
    return op <= OP_FLE;
`else
    return op <= OP_DIV;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] op_lat(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB: return CNT_W'(ADD_LAT);
      OP_MUL:         return CNT_W'(MUL_LAT);
      OP_DIV:         return CNT_W'(DIV_LAT);
      default:        return CNT_W'(1);
    endcase
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [4:0]       rd_q, rd_d;
  logic [31:0]      data_q, data_d;
  logic [2:0]       rflags_q, rflags_d;
  logic             rvalid_q, rvalid_d;
  logic [2:0]       sticky_q, sticky_d;

  logic [31:0]      cap_data;
  logic [2:0]       cap_flags;

`ifdef FALU_CMP_EN
  logic cmp_eq;
  logic cmp_lt;
  logic cmp_nan;

  falu_cmp u_cmp (
    .a_i   (a_q),
    .b_i   (b_q),
    .eq_o  (cmp_eq),
    .lt_o  (cmp_lt),
    .nan_o (cmp_nan)
  );
`endif

  // Value captured at the end of EXEC. Add/sub cannot legitimately report
  // over/underflow from this FALU, so those bits are masked.
  always_comb begin
    cap_data  = falu_result;
    cap_flags = {falu_exc, falu_ovf, falu_unf};
    if (is_addsub(op_q)) begin
      cap_flags[FLG_OVF] = 1'b0;
      cap_flags[FLG_UNF] = 1'b0;
    end
`ifdef FALU_CMP_EN
    if (is_cmp(op_q)) begin
      cap_flags = cmp_nan ? FLAGS_INVALID : 3'b000;
      case (op_q)
        OP_FEQ:  cap_data = {31'd0, cmp_eq};
        OP_FLT:  cap_data = {31'd0, cmp_lt};
        default: cap_data = {31'd0, cmp_lt | cmp_eq};
      endcase
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    rd_d     = rd_q;
    data_d   = data_q;
    rflags_d = rflags_q;
    rvalid_d = rvalid_q;
    // Clear first; a same-cycle accrual below ORs onto the cleared value.
    sticky_d = flags_clr ? 3'b000 : sticky_q;

    if (flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      op_d     = OP_NONE;
      rvalid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_d  = req_a;
            b_d  = req_b;
            op_d = req_op;
            rd_d = req_rd;
            if (op_legal(req_op)) begin
              cnt_d   = op_lat(req_op);
              state_d = EXEC;
            end else begin
              data_d   = '0;
              rflags_d = FLAGS_INVALID;
              rvalid_d = 1'b1;
              state_d  = DONE;
            end
          end
        end
        EXEC: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            data_d   = cap_data;
            rflags_d = cap_flags;
            rvalid_d = 1'b1;
            state_d  = DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rvalid_d = 1'b0;
            op_d     = OP_NONE;
            state_d  = IDLE;
            sticky_d = sticky_d | rflags_q;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_NONE;
      rd_q     <= '0;
      data_q   <= '0;
      rflags_q <= '0;
      rvalid_q <= 1'b0;
      sticky_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      data_q   <= data_d;
      rflags_q <= rflags_d;
      rvalid_q <= rvalid_d;
      sticky_q <= sticky_d;
    end
  end

  assign req_ready    = (state_q == IDLE) && !flush;
  assign busy         = (state_q != IDLE);
  assign falu_a       = a_q;
  assign falu_b       = b_q;
  assign falu_op      = op_q;
  assign rsp_valid    = rvalid_q;
  assign rsp_data     = data_q;
  assign rsp_rd       = rd_q;
  assign rsp_flags    = rflags_q;
  assign flags_sticky = sticky_q;

endmodule

// File: tb/tb_falu_issue_ctrl.sv
module tb_falu_issue_ctrl;

  localparam int ADD_LAT = 2;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 6;

`ifdef FALU_CMP_EN
  localparam bit CMP_EN = 1'b1;
`else
  localparam bit CMP_EN = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'd0;
  logic [31:0] req_a = 32'd0;
  logic [31:0] req_b = 32'd0;
  logic [4:0]  req_rd = 5'd0;
  logic [31:0] falu_a;
  logic [31:0] falu_b;
  logic [3:0]  falu_op;
  logic [31:0] falu_result;
  logic        falu_exc;
  logic        falu_ovf;
  logic        falu_unf;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [2:0]  rsp_flags;
  logic [2:0]  flags_sticky;
  logic        flags_clr = 1'b0;
  logic        busy;

  always #5 CLK = ~CLK;

  falu_issue_ctrl #(
    .ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)
  ) dut (
    .CLK(CLK), .RESET(RESET), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
    .falu_a(falu_a), .falu_b(falu_b), .falu_op(falu_op),
    .falu_result(falu_result), .falu_exc(falu_exc), .falu_ovf(falu_ovf),
    .falu_unf(falu_unf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_flags(rsp_flags),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr), .busy(busy)
  );

  function automatic int need(input logic [3:0] op);
    case (op)
      4'd0, 4'd1: return ADD_LAT;
      4'd2:       return MUL_LAT;
      4'd3:       return DIV_LAT;
      default:    return 1;
    endcase
  endfunction

  // Fake FALU as a multi-cycle path: output is garbage until operands and
  // opcode have been stable for the op's settle time.
  logic [31:0] f_res = 32'd0;
  logic [2:0]  f_fl = 3'd0;
  logic [67:0] fprev = '0;
  int          hold = 0;

  always @(negedge CLK) begin
    if ({falu_a, falu_b, falu_op} == fprev) hold = hold + 1;
    else hold = 1;
    fprev = {falu_a, falu_b, falu_op};
  end

  assign falu_result = (hold >= need(falu_op)) ? f_res : 32'hDEADBEEF;
  assign {falu_exc, falu_ovf, falu_unf} = (hold >= need(falu_op)) ? f_fl : 3'b111;

  // Compare result from IEEE ordering: map sign/magnitude to a signed key.
  function automatic int fkey(input logic [31:0] x);
    int m;
    m = int'({1'b0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  function automatic bit fnan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  task automatic cmp_model(input logic [3:0] op, input logic [31:0] a, b,
                           output logic [31:0] d, output logic [2:0] f);
    bit r;
    if (fnan(a) || fnan(b)) begin
      d = 32'd0;
      f = 3'b100;
    end else begin
      if (op == 4'd4)      r = (fkey(a) == fkey(b));
      else if (op == 4'd5) r = (fkey(a) < fkey(b));
      else                 r = (fkey(a) <= fkey(b));
      d = r ? 32'd1 : 32'd0;
      f = 3'b000;
    end
  endtask

  // Transaction-level model: one outstanding op, due time from its latency.
  int          cyc = 0;
  int          m_due = 0;
  bit          m_pend = 1'b0;
  bit          m_valid = 1'b0;
  logic [31:0] m_fa = 32'd0;
  logic [31:0] m_fb = 32'd0;
  logic [3:0]  m_fop = 4'hF;
  logic [4:0]  m_rd = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [2:0]  m_flags = 3'd0;
  logic [2:0]  m_sticky = 3'd0;

  always @(posedge CLK) begin
    bit idle, hs;
    cyc = cyc + 1;
    if (RESET) begin
      m_pend = 0; m_valid = 0; m_sticky = 0; m_fa = 0; m_fb = 0;
      m_fop = 4'hF; m_rd = 0; m_data = 0; m_flags = 0;
    end else if (flush) begin
      m_pend = 0; m_valid = 0; m_fop = 4'hF;
      if (flags_clr) m_sticky = 0;
    end else begin
      idle = !m_pend && !m_valid;
      hs   = m_valid && rsp_ready;
      if (flags_clr) m_sticky = hs ? m_flags : 3'b000;
      else if (hs)   m_sticky = m_sticky | m_flags;
      if (hs) begin
        m_valid = 0;
        m_fop   = 4'hF;
      end else if (m_pend && cyc == m_due) begin
        m_pend  = 0;
        m_valid = 1;
      end
      if (idle && req_valid) begin
        m_fa = req_a; m_fb = req_b; m_fop = req_op; m_rd = req_rd;
        if (req_op <= 4'd3) begin
          m_pend  = 1;
          m_due   = cyc + need(req_op);
          m_data  = f_res;
          m_flags = (req_op <= 4'd1) ? {f_fl[2], 2'b00} : f_fl;
        end else if (CMP_EN && req_op <= 4'd6) begin
          m_pend = 1;
          m_due  = cyc + 1;
          cmp_model(req_op, req_a, req_b, m_data, m_flags);
        end else begin
          m_valid = 1;
          m_data  = 32'd0;
          m_flags = 3'b100;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit idle;
    idle = !m_pend && !m_valid;
    chk("req_ready", 32'(req_ready), 32'(idle && !flush));
    chk("busy", 32'(busy), 32'(!idle));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("flags_sticky", 32'(flags_sticky), 32'(m_sticky));
    chk("falu_op", 32'(falu_op), 32'(m_fop));
    if (m_fop != 4'hF) begin
      chk("falu_a", falu_a, m_fa);
      chk("falu_b", falu_b, m_fb);
    end
    if (m_valid) begin
      chk("rsp_data", rsp_data, m_data);
      chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
      chk("rsp_rd", 32'(rsp_rd), 32'(m_rd));
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_falu_a"}, falu_a, 32'd0);
    chk({nm, "_falu_b"}, falu_b, 32'd0);
    chk({nm, "_falu_op"}, 32'(falu_op), 32'hF);
    chk({nm, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({nm, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_rsp_data"}, rsp_data, 32'd0);
    chk({nm, "_rsp_rd"}, 32'(rsp_rd), 32'd0);
    chk({nm, "_rsp_flags"}, 32'(rsp_flags), 32'd0);
    chk({nm, "_sticky"}, 32'(flags_sticky), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called at posedge+1 with the controller idle; returns at posedge+1 idle.
  task automatic run_op(input string nm, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] res,
                        input logic [2:0] fl, input int hold_n, input bit clr_hs,
                        input int exp_lat, input logic [31:0] exp_data,
                        input logic [2:0] exp_flags);
    int n;
    bit seen;
    f_res = res; f_fl = fl;
    req_op = op; req_a = a; req_b = b; req_rd = rd; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0; seen = 0;
    while (n < 30 && !seen) begin
      @(negedge CLK);
      n = n + 1;
      if (rsp_valid) seen = 1;
    end
    chk({nm, "_latency"}, 32'(n), 32'(exp_lat));
    chk({nm, "_data"}, rsp_data, exp_data);
    chk({nm, "_flags"}, 32'(rsp_flags), 32'(exp_flags));
    chk({nm, "_rd"}, 32'(rsp_rd), 32'(rd));
    for (int i = 0; i < hold_n; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_hold_data"}, rsp_data, exp_data);
      chk({nm, "_hold_rd"}, 32'(rsp_rd), 32'(rd));
      chk({nm, "_hold_ready"}, 32'(req_ready), 32'd0);
      chk({nm, "_hold_busy"}, 32'(busy), 32'd1);
    end
    rsp_ready = 1'b1;
    flags_clr = clr_hs;
    @(posedge CLK); #1;
    rsp_ready = 1'b0;
    flags_clr = 1'b0;
    chk({nm, "_after_valid"}, 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    fork
      begin : compare_loop
        forever begin
          @(negedge CLK);
          if (chk_on) compare_all();
        end
      end
      begin : stimulus
        repeat (3) @(posedge CLK);
        #1;
        chk_reset("reset");
        RESET = 1'b0;
        chk_on = 1'b1;
        @(posedge CLK); #1;

        run_op("add", 4'd0, 32'h3F800000, 32'h40000000, 5'd1, 32'h40400000,
               3'b000, 0, 1'b0, 3, 32'h40400000, 3'b000);
        chk("add_sticky", 32'(flags_sticky), 32'h0);

        run_op("mul_ovf", 4'd2, 32'h7F000000, 32'h7F000000, 5'd2, 32'h7F800000,
               3'b010, 0, 1'b0, 4, 32'h7F800000, 3'b010);
        chk("mul_sticky", 32'(flags_sticky), 32'h2);

        run_op("add_clr", 4'd0, 32'h40000000, 32'h40000000, 5'd3, 32'h40800000,
               3'b000, 0, 1'b1, 3, 32'h40800000, 3'b000);
        chk("clr_sticky", 32'(flags_sticky), 32'h0);

        run_op("sub_mask", 4'd1, 32'h3F800000, 32'h3F800000, 5'd4, 32'h00000000,
               3'b111, 0, 1'b0, 3, 32'h00000000, 3'b100);
        chk("sub_sticky", 32'(flags_sticky), 32'h4);

        run_op("mul_clr", 4'd2, 32'h00800000, 32'h00800000, 5'd9, 32'h00000000,
               3'b001, 0, 1'b1, 4, 32'h00000000, 3'b001);
        chk("mulclr_sticky", 32'(flags_sticky), 32'h1);

        run_op("div_bp", 4'd3, 32'h40C00000, 32'h40000000, 5'd5, 32'h40400000,
               3'b000, 5, 1'b0, 7, 32'h40400000, 3'b000);
        chk("div_sticky", 32'(flags_sticky), 32'h1);

        // Flush during mul EXEC with a competing request in the same cycle.
        f_res = 32'h40000000; f_fl = 3'b010;
        req_op = 4'd2; req_a = 32'h3F800000; req_b = 32'h40000000;
        req_rd = 5'd6; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        @(posedge CLK); #1;
        flush = 1'b1; req_valid = 1'b1; req_op = 4'd0;
        req_a = 32'h3F800000; req_b = 32'h3F800000; req_rd = 5'd8;
        @(posedge CLK); #1;
        flush = 1'b0; req_valid = 1'b0;
        chk("flush_valid", 32'(rsp_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_op", 32'(falu_op), 32'hF);
        chk("flush_sticky", 32'(flags_sticky), 32'h1);
        repeat (6) begin
          @(negedge CLK);
          chk("flush_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge CLK); #1;

        run_op("illegal", 4'd9, 32'h3F800000, 32'h3F800000, 5'd7, 32'h12345678,
               3'b000, 0, 1'b0, 1, 32'h00000000, 3'b100);
        chk("ill_sticky", 32'(flags_sticky), 32'h5);

`ifdef FALU_CMP_EN
        run_op("flt", 4'd5, 32'hBF800000, 32'h3F800000, 5'd10, 32'h0,
               3'b000, 0, 1'b0, 2, 32'd1, 3'b000);
        run_op("feq_zero", 4'd4, 32'h80000000, 32'h00000000, 5'd11, 32'h0,
               3'b000, 0, 1'b0, 2, 32'd1, 3'b000);
        run_op("feq_nan", 4'd4, 32'h7FC00000, 32'h3F800000, 5'd12, 32'h0,
               3'b000, 0, 1'b0, 2, 32'd0, 3'b100);
        run_op("fle_eq", 4'd6, 32'h40000000, 32'h40000000, 5'd13, 32'h0,
               3'b000, 0, 1'b0, 2, 32'd1, 3'b000);
`else
        run_op("op4_illegal", 4'd4, 32'h80000000, 32'h00000000, 5'd11, 32'h0,
               3'b000, 0, 1'b0, 1, 32'd0, 3'b100);
`endif
        chk("pre_reset_sticky", 32'(flags_sticky), 32'h5);

        // Reset in the middle of a div.
        f_res = 32'h40400000; f_fl = 3'b000;
        req_op = 4'd3; req_a = 32'h40C00000; req_b = 32'h40000000;
        req_rd = 5'd14; req_valid = 1'b1;
        @(posedge CLK); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("mid_div_busy", 32'(busy), 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk_reset("reset_mid");
        RESET = 1'b0;
        @(posedge CLK); #1;

        run_op("add_after_rst", 4'd0, 32'h3F800000, 32'h3F800000, 5'd15,
               32'h40000000, 3'b000, 0, 1'b0, 3, 32'h40000000, 3'b000);
        repeat (3) @(posedge CLK);
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: bench did not complete within time limit");
        bad = bad + 1;
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/falu_issue_ctrl.md
Name: falu_issue_ctrl

Overview:
Sequencer between the RV32 pipeline EX stage and the combinational FALU (add/sub/mul/div).
- Accepts one FP request at a time with a valid/ready handshake.
- Drives and holds stable FALU operands/opcode for a per-op settle latency (multi-cycle path on FPGA), then captures result and flags into a response register.
- Accrues sticky exception flags for the CSR unit; supports pipeline flush.

Parameters:
ADD_LAT, 2, cycles FALU held for op 0/1 before capture (min 1)
MUL_LAT, 3, cycles held for op 2 (min 1)
DIV_LAT, 6, cycles held for op 3 (min 1)
CNT_W, 4, latency counter width; must hold max(*_LAT)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
flush  in  1  cancel in-flight op, no response produced
req_valid  in  1  request present
req_ready  out  1  controller can accept
req_op  in  4  0 add, 1 sub, 2 mul, 3 div (4-6 compare, see Optional Feature)
req_a  in  32  IEEE-754 single operand A
req_b  in  32  operand B
req_rd  in  5  destination tag, returned unchanged
falu_a  out  32  to FALU a_operand
falu_b  out  32  to FALU b_operand
falu_op  out  4  to FALU Operation
falu_result  in  32  FALU ALU_Output
falu_exc  in  1  FALU Exception
falu_ovf  in  1  FALU Overflow
falu_unf  in  1  FALU Underflow
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts
rsp_data  out  32  result
rsp_rd  out  5  tag
rsp_flags  out  3  {exc,ovf,unf} of this op
flags_sticky  out  3  accrued {exc,ovf,unf}
flags_clr  in  1  clear sticky flags
busy  out  1  high in EXEC or DONE (stall hint)

Behaviour:
- Reset: state IDLE; every output 0 except req_ready=1; falu_op=4'hF (selects no FALU unit); counter 0.
- Clock and reset: single clock CLK; reset RESET is synchronous and active-high.
- IDLE: req_ready=1 only when flush=0.
  - On req_valid&&req_ready: register a, b, op, rd to falu_a/falu_b/falu_op/rsp_rd.
  - Load counter with the op latency. Go to EXEC.
- EXEC: falu_* held constant. Counter decrements each cycle. When counter==1, capture next edge:
  - rsp_data<=falu_result, rsp_flags<={falu_exc,falu_ovf,falu_unf}.
  - add/sub force ovf=unf=0.
  - rsp_valid<=1, go to DONE.
  - Request-to-rsp_valid latency = op latency + 1 cycles.
- DONE: rsp_valid held with stable data until rsp_ready. On handshake:
  - rsp_valid<=0, falu_op<=4'hF, go IDLE.
  - flags_sticky |= rsp_flags.
  - No back-to-back issue; next acceptance is in the following cycle.
- Illegal op (op>3, or 4-6 without the optional feature):
  - Accepted; go directly to DONE next cycle.
  - rsp_data=0, rsp_flags=3'b100.
- flush: in any state, next state IDLE, rsp_valid<=0, falu_op<=4'hF, sticky flags untouched.
  - flush wins over a simultaneous request or response handshake; a response handshake in the same cycle is discarded and flags do not accrue.
- flags_clr with a simultaneous accrual: flags_sticky<=rsp_flags (clear, then accrue the new op).
- RESET mid-operation: identical to the reset values above; sticky flags cleared.
- Latency parameter < 1 is illegal; elaboration-time check.

Optional Feature:
FALU_CMP_EN:
- Defined: ops 4 FEQ, 5 FLT, 6 FLE are handled by an internal comparator on the registered operands, not the FALU.
  - Latency 1 (rsp_valid 2 cycles after accept).
  - rsp_data = 32'd1 if true else 0.
  - rsp_flags = 3'b100 if either operand is NaN, else 0.
  - +0 == -0.
- Undefined: ops 4-6 take the illegal-op path.

Decomposition:
- Package falu_pkg holds:
  - op codes: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_FEQ=4, OP_FLT=5, OP_FLE=6, OP_NONE=4'hF
  - state encoding: IDLE, EXEC, DONE
  - flag bit indices
- One natural sub-module: falu_cmp, a combinational sign/magnitude compare producing eq/lt/nan. Instantiated only under FALU_CMP_EN.

Test Plan:
- Add: a=0x3F800000, b=0x40000000, op 0, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept, rsp_data 0x40400000, rsp_flags 0, falu_* stable throughout.
- Mul overflow: a=b=0x7F000000, op 2 -> rsp_valid 4 cycles after accept, rsp_flags[1]=1; flags_sticky=3'b010 after handshake; flags_clr same cycle as next clean op -> sticky 0.
- Backpressure: div 0x40C00000/0x40000000 with rsp_ready=0 for 5 cycles -> rsp_data 0x40400000 and rsp_rd held, req_ready=0, busy=1 until handshake.
- Flush in EXEC of a mul, with req_valid asserted the same cycle -> no rsp_valid, IDLE next cycle, request not accepted, sticky unchanged.
- Illegal op 9 with rd=7 -> rsp_valid 1 cycle after accept, rsp_data 0, rsp_flags 3'b100, rsp_rd 7; RESET asserted during a subsequent div EXEC -> all outputs at reset values next cycle.
- FALU_CMP_EN: FLT with a=0xBF800000, b=0x3F800000 -> rsp_data 1; FEQ 0x80000000 vs 0x00000000 -> 1; FEQ with 0x7FC00000 -> data 0, flags 3'b100.
